dbi_rx_decoder: RTL and testbench

- Receive-side counterpart of the data-bus-inversion (DBI) transmitter.
- Accepts encoded bus words plus an inversion flag through a valid/ready handshake and restores the original data.
- Checks each word against the DBI transition rule and counts inverted words.
- Buffers decoded words in a small FIFO so downstream backpressure does not stall the bus protocol.

---
 rtl/dbi_rx_decoder.sv | 129 ++++++++++++
 tb/tb_dbi_rx_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dbi_rx_decoder.sv
// DBI receive decoder: restores inverted words, checks the transition rule,
// counts inverted beats and buffers decoded words in a small FIFO.
module dbi_rx_decoder #(
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] bus_in,
  input  logic                 inv_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 dbi_err,
  output logic [CNT_W-1:0]     inv_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned HW   = $clog2(WORD_SIZE + 1);
  localparam int unsigned HALF = WORD_SIZE / 2;

  logic [WORD_SIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [WORD_SIZE-1:0] r_prev_bus;
  logic [WORD_SIZE-1:0] r_data_out;
  logic                 r_valid_out;
  logic                 r_ready_out;
  logic                 r_dbi_err;
  logic [CNT_W-1:0]     r_inv_count;

  logic                 w_accept;
  logic                 w_pop;
  logic [WORD_SIZE-1:0] w_decoded;
  logic [WORD_SIZE-1:0] w_diff;
  logic [HW-1:0]        w_hd;
  logic                 w_violation;
  logic [CW-1:0]        w_count_next;
  logic [WORD_SIZE-1:0] w_head_next;

  assign w_accept    = valid_in & r_ready_out;
  assign w_pop       = r_valid_out & ready_in;
  assign w_decoded   = inv_in ? ~bus_in : bus_in;
  assign w_diff      = bus_in ^ r_prev_bus;
  assign w_violation = (w_hd > HW'(HALF));

  // Hamming distance between the incoming raw word and the previous raw word
  always_comb begin
    w_hd = '0;
    for (int i = 0; i < int'(WORD_SIZE); i++) begin
      w_hd = w_hd + HW'(w_diff[i]);
    end
  end

  // Occupancy after this edge
  always_comb begin
    w_count_next = r_count;
    if (w_accept && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_accept && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // FIFO head after this edge; holds the last value when the FIFO drains
  always_comb begin
    w_head_next = r_data_out;
    if (w_pop) begin
      if (r_count > CW'(1)) begin
        w_head_next = r_mem[r_rptr + AW'(1)];
      end else if (w_accept) begin
        w_head_next = w_decoded;
      end
    end else if ((r_count == CW'(0)) && w_accept) begin
      w_head_next = w_decoded;
    end
  end

  // FIFO storage; contents are meaningless until written so no reset is needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wptr] <= w_decoded;
    end
  end

  // Pointers, occupancy and registered handshake/data outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_ready_out <= 1'b1;
    end else begin
      if (w_accept) r_wptr <= r_wptr + AW'(1);
      if (w_pop)    r_rptr <= r_rptr + AW'(1);
      r_count     <= w_count_next;
      r_data_out  <= w_head_next;
      r_valid_out <= (w_count_next != CW'(0));
      r_ready_out <= (w_count_next != CW'(DEPTH));
    end
  end

  // Transition tracking, sticky error and saturating inversion counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_bus  <= '0;
      r_dbi_err   <= 1'b0;
      r_inv_count <= '0;
    end else if (w_accept) begin
      r_prev_bus <= bus_in;
      if (w_violation) r_dbi_err <= 1'b1;
      if (inv_in && !(&r_inv_count)) r_inv_count <= r_inv_count + CNT_W'(1);
    end
  end

  assign ready_out = r_ready_out;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign dbi_err   = r_dbi_err;
  assign inv_count = r_inv_count;

endmodule

// File: tb/tb_dbi_rx_decoder.sv
// Self-checking bench for dbi_rx_decoder against a queue-based reference model.
module tb_dbi_rx_decoder;

  localparam int unsigned WS    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [WS-1:0] bus_in = '0;
  logic          inv_in = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [WS-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic          dbi_err;
  logic [CNT_W-1:0] inv_count;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [WS-1:0] q[$];
  logic [WS-1:0] got[$];
  logic [WS-1:0] m_prev = '0;
  logic [WS-1:0] m_data = '0;
  logic          m_err  = 1'b0;
  int            m_cnt  = 0;
  logic          last_acc;

  dbi_rx_decoder #(.WORD_SIZE(WS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .inv_in(inv_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .dbi_err(dbi_err),
    .inv_count(inv_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ready_out", 32'(ready_out), 32'(q.size() != DEPTH));
    check("valid_out", 32'(valid_out), 32'(q.size() != 0));
    check("data_out",  32'(data_out),  32'(m_data));
    check("dbi_err",   32'(dbi_err),   32'(m_err));
    check("inv_count", 32'(inv_count), 32'(m_cnt));
  endtask

  // One clock of stimulus; the model advances from the rules, then outputs are compared
  task automatic cycle(input logic v, input logic [WS-1:0] b, input logic inv, input logic rdy);
    logic acc, pop;
    @(negedge clk);
    valid_in = v; bus_in = b; inv_in = inv; ready_in = rdy;
    acc = v && (q.size() < DEPTH);
    pop = rdy && (q.size() != 0);
    #1;
    if (pop) got.push_back(data_out);
    last_acc = acc;
    @(posedge clk);
    if (pop) q.delete(0);
    if (acc) begin
      q.push_back(inv ? ~b : b);
      if ($countones(b ^ m_prev) > WS / 2) m_err = 1'b1;
      m_prev = b;
      if (inv && m_cnt < SAT) m_cnt++;
    end
    if (q.size() != 0) m_data = q[0];
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    repeat (n) @(posedge clk);
    q.delete(); m_prev = '0; m_data = '0; m_err = 1'b0; m_cnt = 0;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // reset then idle
    do_reset(2);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("idle_valid", 32'(valid_out), 32'd0);
    check("idle_ready", 32'(ready_out), 32'd1);
    check("idle_data",  32'(data_out),  32'd0);
    check("idle_err",   32'(dbi_err),   32'd0);
    check("idle_cnt",   32'(inv_count), 32'd0);

    // decode with ready_in=1
    cycle(1'b1, 4'b0011, 1'b0, 1'b1);
    check("dec_plain", 32'(data_out), 32'h3);
    cycle(1'b1, 4'b0010, 1'b1, 1'b1);
    check("dec_inv",     32'(data_out),  32'hD);
    check("dec_inv_cnt", 32'(inv_count), 32'd1);
    check("dec_inv_err", 32'(dbi_err),   32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // rule violation from prev_bus=0, sticky over legal beats, cleared by reset
    do_reset(1);
    cycle(1'b1, 4'b0111, 1'b0, 1'b1);
    check("viol_set", 32'(dbi_err), 32'd1);
    cycle(1'b1, 4'b0110, 1'b0, 1'b1);
    cycle(1'b1, 4'b0100, 1'b0, 1'b1);
    cycle(1'b1, 4'b0101, 1'b0, 1'b1);
    cycle(1'b1, 4'b0001, 1'b0, 1'b1);
    cycle(1'b1, 4'b0000, 1'b0, 1'b1);
    check("viol_sticky", 32'(dbi_err), 32'd1);
    do_reset(1);
    check("viol_clear", 32'(dbi_err), 32'd0);

    // backpressure: A,B fill the FIFO, C is held by the source until taken
    got.delete();
    cycle(1'b1, 4'd1, 1'b0, 1'b0);
    cycle(1'b1, 4'd2, 1'b0, 1'b0);
    check("bp_full", 32'(ready_out), 32'd0);
    cycle(1'b1, 4'd3, 1'b0, 1'b0);
    check("bp_c_held", 32'(last_acc), 32'd0);
    last_acc = 1'b0;
    for (int k = 0; k < 8 && !last_acc; k++) cycle(1'b1, 4'd3, 1'b0, 1'b1);
    check("bp_c_taken", 32'(last_acc), 32'd1);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b0, 1'b1);
    check("bp_order_n", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      for (int k = 0; k < 3; k++) check("bp_order", 32'(got[k]), 32'(k + 1));
    end

    // simultaneous push/pop at count=1
    cycle(1'b1, 4'd5, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, WS'($urandom), 1'($urandom), 1'b1);
      check("pp_ready", 32'(ready_out), 32'd1);
      check("pp_valid", 32'(valid_out), 32'd1);
    end
    for (int k = 0; k < 2; k++) cycle(1'b0, '0, 1'b0, 1'b1);

    // randomized traffic
    do_reset(1);
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, WS'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0, 1'b1);

    // inversion counter saturation
    for (int k = 0; k < 300; k++) cycle(1'b1, WS'($urandom), 1'b1, 1'b1);
    check("sat_cnt", 32'(inv_count), 32'(SAT));
    cycle(1'b1, 4'hA, 1'b1, 1'b1);
    check("sat_hold", 32'(inv_count), 32'(SAT));
    for (int k = 0; k < 2; k++) cycle(1'b0, '0, 1'b0, 1'b1);

    // reset with two words buffered; they must never appear
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    cycle(1'b1, 4'h6, 1'b1, 1'b0);
    check("mid_full", 32'(ready_out), 32'd0);
    do_reset(1);
    check("mid_valid", 32'(valid_out), 32'd0);
    check("mid_cnt",   32'(inv_count), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("mid_dropped", 32'(valid_out), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
